// File: rtl/host_button.sv
// host_button: Avalon-MM slave input port for board push-buttons and switches.
// External inputs are synchronized, debounced and edge-detected; captured
// edges raise a maskable level interrupt to the host CPU.
module host_button #(
    parameter int WIDTH      = 4,
    parameter int DB_TICK    = 1000,
    parameter int DB_SAMPLES = 3,
    parameter int EDGE_TYPE  = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE    = 2'd2;

    // Bus handshake: a write is taken on every cycle with chipselect=1 and
    // write_n=0 (no wait states); reads are combinational and side-effect free.
    logic wr_en;
    assign wr_en = chipselect & ~write_n;

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] deb_q, prev_q;
    logic [WIDTH-1:0] rise, fall, ev;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] clr;

    // Two-flop synchronizer for the asynchronous external inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
        end
    end

    generate
        if (DB_TICK > 0) begin : g_debounce
            localparam int PW = (DB_TICK > 1) ? $clog2(DB_TICK) : 1;
            localparam logic [PW-1:0] TICK_LAST = PW'(DB_TICK - 1);
            localparam logic [3:0]    SAMPLES   = 4'(DB_SAMPLES);

            logic [PW-1:0]          presc_q, presc_d;
            logic                   tick;
            logic [WIDTH-1:0]       deb_d;
            logic [WIDTH-1:0][3:0]  cnt_q, cnt_d;

            // Prescaler wraps at DB_TICK-1 and flags a sample tick on that count.
            always_comb begin
                tick    = (presc_q == TICK_LAST);
                presc_d = tick ? '0 : presc_q + PW'(1);
            end

            // Per-bit filter: a new level is accepted after DB_SAMPLES
            // consecutive ticks that disagree with the current debounced level.
            always_comb begin
                deb_d = deb_q;
                cnt_d = cnt_q;
                if (tick) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (sync2_q[i] != deb_q[i]) begin
                            if (cnt_q[i] + 4'd1 == SAMPLES) begin
                                deb_d[i] = sync2_q[i];
                                cnt_d[i] = '0;
                            end else begin
                                cnt_d[i] = cnt_q[i] + 4'd1;
                            end
                        end else begin
                            cnt_d[i] = '0;
                        end
                    end
                end
            end

            // Prescaler, persistence counters and debounced level.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    presc_q <= '0;
                    cnt_q   <= '0;
                    deb_q   <= '0;
                end else begin
                    presc_q <= presc_d;
                    cnt_q   <= cnt_d;
                    deb_q   <= deb_d;
                end
            end
        end else begin : g_bypass
            // No filtering: the synchronized level is registered once.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) deb_q <= '0;
                else          deb_q <= sync2_q;
            end
        end
    endgenerate

    // Select which transitions of the debounced level count as events.
    always_comb begin
        rise = deb_q & ~prev_q;
        fall = ~deb_q & prev_q;
        if (EDGE_TYPE == 0)      ev = rise;
        else if (EDGE_TYPE == 1) ev = fall;
        else                     ev = rise | fall;
    end

    // Register writes; a new event beats a simultaneous write-1-to-clear.
    always_comb begin
        clr    = '0;
        mask_d = mask_q;
        if (wr_en && address == ADDR_EDGE)    clr    = writedata[WIDTH-1:0];
        if (wr_en && address == ADDR_IRQMASK) mask_d = writedata[WIDTH-1:0];
        edge_d = (edge_q & ~clr) | ev;
    end

    // Previous-level, interrupt mask and edge capture registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= '0;
            mask_q <= '0;
            edge_q <= '0;
        end else begin
            prev_q <= deb_q;
            mask_q <= mask_d;
            edge_q <= edge_d;
        end
    end

    // Read mux, zero-extended to the bus width.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = deb_q;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = mask_q;
            ADDR_EDGE:    readdata[WIDTH-1:0] = edge_q;
            default:      readdata = '0;
        endcase
    end

    assign irq = |(edge_q & mask_q);

    logic unused_wdata;
    assign unused_wdata = ^writedata;
endmodule

// File: tb/tb_host_button.sv
// tb_host_button: self-checking bench for host_button. Instance A uses a
// short debounce (DB_TICK=4, DB_SAMPLES=3, rising edges) and is followed by a
// behavioural model; instance B bypasses debounce and captures any edge.
module tb_host_button;
    localparam int TICK_A = 4;
    localparam int SAMP_A = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  a_addr = '0, b_addr = '0;
    logic        a_cs = 1'b0, a_wn = 1'b1, b_cs = 1'b0, b_wn = 1'b1;
    logic [31:0] a_wdata = '0, b_wdata = '0;
    logic [3:0]  a_in = '0, b_in = '0;
    logic [31:0] a_rdata, b_rdata;
    logic        a_irq, b_irq;

    host_button #(.WIDTH(4), .DB_TICK(4), .DB_SAMPLES(3), .EDGE_TYPE(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(a_addr), .chipselect(a_cs),
        .write_n(a_wn), .writedata(a_wdata), .in_port(a_in),
        .readdata(a_rdata), .irq(a_irq)
    );

    host_button #(.WIDTH(4), .DB_TICK(0), .DB_SAMPLES(3), .EDGE_TYPE(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .address(b_addr), .chipselect(b_cs),
        .write_n(b_wn), .writedata(b_wdata), .in_port(b_in),
        .readdata(b_rdata), .irq(b_irq)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model of instance A: m_k counts clock edges since reset,
    // every TICK_A-th edge is a sample point, and a bit's accepted level
    // flips after SAMP_A sample points in a row that disagree with it.
    int         m_k;
    int         m_run [4];
    logic [3:0] m_s1, m_s2, m_deb, m_prev, m_cap, m_mask;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_k <= 0;
            m_s1 <= '0; m_s2 <= '0; m_deb <= '0; m_prev <= '0;
            m_cap <= '0; m_mask <= '0;
            for (int i = 0; i < 4; i++) m_run[i] <= 0;
        end else begin
            logic [3:0] nd;
            logic [3:0] clr;
            nd = m_deb;
            if ((m_k % TICK_A) == TICK_A - 1) begin
                for (int i = 0; i < 4; i++) begin
                    if (m_s2[i] != m_deb[i]) begin
                        if (m_run[i] + 1 >= SAMP_A) begin
                            nd[i] = m_s2[i];
                            m_run[i] <= 0;
                        end else begin
                            m_run[i] <= m_run[i] + 1;
                        end
                    end else begin
                        m_run[i] <= 0;
                    end
                end
            end
            clr = (a_cs && !a_wn && a_addr == 2'd2) ? a_wdata[3:0] : 4'h0;
            m_cap <= (m_cap & ~clr) | (m_deb & ~m_prev);
            if (a_cs && !a_wn && a_addr == 2'd1) m_mask <= a_wdata[3:0];
            m_prev <= m_deb;
            m_deb  <= nd;
            m_s2   <= m_s1;
            m_s1   <= a_in;
            m_k    <= m_k + 1;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [1:0] ad);
        case (ad)
            2'd0:    return {28'h0, m_deb};
            2'd1:    return {28'h0, m_mask};
            2'd2:    return {28'h0, m_cap};
            default: return 32'h0;
        endcase
    endfunction

    task automatic test_reset();
        a_in = 4'hF; a_addr = 2'd0; a_cs = 1'b0; a_wn = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (a_rdata !== 32'h0 || a_irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold data=%h irq=%b expected data=0 irq=0", a_rdata, a_irq);
        end
        a_addr = 2'd2; #1;
        checks++;
        if (a_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_edgecap got %h expected 0", a_rdata);
        end
        a_addr = 2'd0;
        @(negedge clk);
        reset_n = 1'b1;
        // Sample ticks fall on edges 4, 8 and 12 after release: level accepted at 12.
        for (int c = 1; c <= 20; c++) begin
            logic [31:0] exp;
            @(negedge clk);
            exp = (c >= 12) ? 32'hF : 32'h0;
            checks++;
            if (a_rdata !== exp) begin
                errors++;
                $display("FAIL reset_release_data cycle %0d got %h expected %h", c, a_rdata, exp);
            end
            checks++;
            if (a_irq !== 1'b0) begin
                errors++;
                $display("FAIL reset_release_irq cycle %0d got %b expected 0", c, a_irq);
            end
        end
        a_addr = 2'd2; #1;
        checks++;
        if (a_rdata !== 32'hF) begin
            errors++;
            $display("FAIL reset_release_edgecap got %h expected f", a_rdata);
        end
    endtask

    task automatic test_glitch();
        @(negedge clk);
        a_in = 4'h0; reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            a_in   = (c < 5) ? 4'h1 : 4'h0;
            a_addr = c[0] ? 2'd2 : 2'd0;
            #1;
            checks++;
            if (a_rdata !== 32'h0 || a_irq !== 1'b0) begin
                errors++;
                $display("FAIL glitch cycle %0d addr %0d got %h irq=%b expected 0 irq=0", c, a_addr, a_rdata, a_irq);
            end
        end
    endtask

    task automatic test_mask_irq();
        int n;
        @(negedge clk);
        a_cs = 1'b1; a_wn = 1'b0; a_addr = 2'd1; a_wdata = 32'h2;
        @(negedge clk);
        a_cs = 1'b0; a_wn = 1'b1; #1;
        checks++;
        if (a_rdata !== 32'h2) begin
            errors++;
            $display("FAIL irqmask_readback got %h expected 2", a_rdata);
        end
        a_addr = 2'd2; a_in[1] = 1'b1;
        for (n = 0; n < 40 && !m_cap[1]; n++) begin
            @(negedge clk);
            checks++;
            if (a_irq !== |(m_cap & m_mask)) begin
                errors++;
                $display("FAIL press1_irq cycle %0d got %b expected %b", n, a_irq, |(m_cap & m_mask));
            end
        end
        checks++;
        if (!m_cap[1] || a_rdata !== 32'h2 || a_irq !== 1'b1) begin
            errors++;
            $display("FAIL press1_capture got %h irq=%b expected 2 irq=1 (waited %0d)", a_rdata, a_irq, n);
        end
        a_cs = 1'b1; a_wn = 1'b0; a_wdata = 32'h2;
        @(negedge clk);
        a_cs = 1'b0; a_wn = 1'b1; #1;
        checks++;
        if (a_rdata !== 32'h0 || a_irq !== 1'b0) begin
            errors++;
            $display("FAIL clear1 got %h irq=%b expected 0 irq=0", a_rdata, a_irq);
        end
    endtask

    task automatic test_mask_late();
        int n;
        a_in[3] = 1'b1;
        for (n = 0; n < 40 && !m_cap[3]; n++) begin
            @(negedge clk);
            checks++;
            if (a_irq !== 1'b0) begin
                errors++;
                $display("FAIL press3_irq cycle %0d got %b expected 0", n, a_irq);
            end
        end
        checks++;
        if (!m_cap[3] || a_rdata !== 32'h8 || a_irq !== 1'b0) begin
            errors++;
            $display("FAIL press3_capture got %h irq=%b expected 8 irq=0", a_rdata, a_irq);
        end
        a_cs = 1'b1; a_wn = 1'b0; a_addr = 2'd1; a_wdata = 32'hA;
        @(negedge clk);
        a_cs = 1'b0; a_wn = 1'b1; #1;
        checks++;
        if (a_irq !== 1'b1) begin
            errors++;
            $display("FAIL mask_late_irq got %b expected 1", a_irq);
        end
    endtask

    task automatic test_collision();
        int n;
        a_addr = 2'd2; a_in[0] = 1'b1;
        for (n = 0; n < 40 && !m_deb[0]; n++) @(negedge clk);
        checks++;
        if (!m_deb[0]) begin
            errors++;
            $display("FAIL collision_timeout got no accepted press after %0d cycles expected one", n);
        end
        // The event for bit 0 is live this cycle; clear it in the same cycle.
        a_cs = 1'b1; a_wn = 1'b0; a_wdata = 32'h1;
        @(negedge clk);
        a_cs = 1'b0; a_wn = 1'b1; #1;
        checks++;
        if (a_rdata !== 32'h9) begin
            errors++;
            $display("FAIL collision_set_wins got %h expected 9", a_rdata);
        end
    endtask

    task automatic test_random();
        int hold [4];
        for (int i = 0; i < 4; i++) hold[i] = $urandom_range(0, 20);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            checks++;
            if (a_irq !== |(m_cap & m_mask)) begin
                errors++;
                $display("FAIL random_irq cycle %0d got %b expected %b", c, a_irq, |(m_cap & m_mask));
            end
            checks++;
            if (a_rdata !== exp_rd(a_addr)) begin
                errors++;
                $display("FAIL random_read cycle %0d addr %0d got %h expected %h", c, a_addr, a_rdata, exp_rd(a_addr));
            end
            for (int i = 0; i < 4; i++) begin
                if (hold[i] == 0) begin
                    a_in[i] = ~a_in[i];
                    hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(10, 30);
                end else begin
                    hold[i] = hold[i] - 1;
                end
            end
            a_addr  = 2'($urandom_range(0, 3));
            a_cs    = ($urandom_range(0, 3) == 0);
            a_wn    = 1'($urandom_range(0, 1));
            a_wdata = $urandom;
        end
        @(negedge clk);
        a_cs = 1'b0; a_wn = 1'b1;
    endtask

    task automatic test_bypass();
        logic [31:0] exp;
        @(negedge clk);
        b_addr = 2'd2; b_in = 4'h4;
        // Two synchronizer flops, one deb flop, then the capture flop.
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            exp = (c == 4) ? 32'h4 : 32'h0;
            checks++;
            if (b_rdata !== exp) begin
                errors++;
                $display("FAIL bypass_rise cycle %0d got %h expected %h", c, b_rdata, exp);
            end
        end
        b_cs = 1'b1; b_wn = 1'b0; b_wdata = 32'h4;
        @(negedge clk);
        b_cs = 1'b0; b_wn = 1'b1; #1;
        checks++;
        if (b_rdata !== 32'h0) begin
            errors++;
            $display("FAIL bypass_clear got %h expected 0", b_rdata);
        end
        repeat (5) @(negedge clk);
        b_in = 4'h0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            exp = (c == 4) ? 32'h4 : 32'h0;
            checks++;
            if (b_rdata !== exp) begin
                errors++;
                $display("FAIL bypass_fall cycle %0d got %h expected %h", c, b_rdata, exp);
            end
        end
        b_in = 4'hF;
        b_cs = 1'b1; b_wn = 1'b0; b_addr = 2'd1; b_wdata = 32'h3;
        @(negedge clk);
        b_addr = 2'd3; b_wdata = 32'hFFFF_FFFF;
        repeat (6) @(negedge clk);
        b_cs = 1'b0; b_wn = 1'b1; #1;
        checks++;
        if (b_rdata !== 32'h0) begin
            errors++;
            $display("FAIL addr3_read got %h expected 0", b_rdata);
        end
        checks++;
        if (b_irq !== 1'b1) begin
            errors++;
            $display("FAIL bypass_irq got %b expected 1", b_irq);
        end
        b_cs = 1'b1; b_wn = 1'b0; b_addr = 2'd0; b_wdata = 32'h0;
        @(negedge clk);
        b_cs = 1'b0; b_wn = 1'b1; #1;
        checks++;
        if (b_rdata !== 32'hF) begin
            errors++;
            $display("FAIL data_write_ignored got %h expected f", b_rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_glitch();
        test_mask_irq();
        test_mask_late();
        test_collision();
        test_random();
        test_bypass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
